// File: rtl/store_pkg.sv
// Shared constants for the store path: memop encodings, the data-bus address map
// and the timer count-register windows that reject stores.
package store_pkg;

  localparam logic [3:0] MEMOP_SW = 4'd4;
  localparam logic [3:0] MEMOP_SH = 4'd5;
  localparam logic [3:0] MEMOP_SB = 4'd6;

  localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TC1_LO = 32'h0000_7F10;
  localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
  localparam logic [31:0] INT_LO = 32'h0000_7F20;
  localparam logic [31:0] INT_HI = 32'h0000_7F23;

  // Read-only count registers inside each timer block.
  localparam logic [31:0] TC0_CNT_LO = 32'h0000_7F08;
  localparam logic [31:0] TC0_CNT_HI = 32'h0000_7F0B;
  localparam logic [31:0] TC1_CNT_LO = 32'h0000_7F18;
  localparam logic [31:0] TC1_CNT_HI = 32'h0000_7F1B;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
      else       r[8*b +: 8] = old_d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store decode: address-error (AdES) check against the address map
// and construction of byte enables plus lane-aligned write data.
module store_lane_gen
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              valid,
  input  logic [3:0]        memop,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              ovf,
  output logic              is_st,
  output logic              ades,
  output logic [ADDR_W-1:0] word_addr,
  output logic [3:0]        byteen,
  output logic [31:0]       lane_data
);

  logic is_sw, is_sh, is_sb;
  logic misalign, mapped, timer_viol;

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= ADDR_W'(lo)) && (a <= ADDR_W'(hi));
  endfunction

  assign is_sw     = (memop == MEMOP_SW);
  assign is_sh     = (memop == MEMOP_SH);
  assign is_sb     = (memop == MEMOP_SB);
  assign is_st     = valid & (is_sw | is_sh | is_sb);
  assign word_addr = {addr[ADDR_W-1:2], 2'b00};

  assign misalign = (is_sw & (addr[1:0] != 2'b00)) | (is_sh & addr[0]);
  assign mapped   = (addr <= ADDR_W'(DM_HI)) | in_range(addr, TC0_LO, TC0_HI) |
                    in_range(addr, TC1_LO, TC1_HI) | in_range(addr, INT_LO, INT_HI);
  // Partial-word stores may not touch either timer block at all.
  assign timer_viol = in_range(addr, TC0_CNT_LO, TC0_CNT_HI) |
                      in_range(addr, TC1_CNT_LO, TC1_CNT_HI) |
                      ((is_sh | is_sb) & in_range(addr, TC0_LO, TC1_HI));
  assign ades = is_st & (ovf | misalign | ~mapped | timer_viol);

  always_comb begin
    byteen    = 4'b0000;
    lane_data = 32'h0000_0000;
    case (memop)
      MEMOP_SW: begin
        byteen    = 4'b1111;
        lane_data = wdata;
      end
      MEMOP_SH: begin
        if (addr[1]) begin
          byteen    = 4'b1100;
          lane_data = {wdata[15:0], 16'h0000};
        end else begin
          byteen    = 4'b0011;
          lane_data = {16'h0000, wdata[15:0]};
        end
      end
      MEMOP_SB: begin
        case (addr[1:0])
          2'd0:    begin byteen = 4'b0001; lane_data = {24'h000000, wdata[7:0]}; end
          2'd1:    begin byteen = 4'b0010; lane_data = {16'h0000, wdata[7:0], 8'h00}; end
          2'd2:    begin byteen = 4'b0100; lane_data = {8'h00, wdata[7:0], 16'h0000}; end
          default: begin byteen = 4'b1000; lane_data = {wdata[7:0], 24'h000000}; end
        endcase
      end
      default: begin
        byteen    = 4'b0000;
        lane_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/store_queue_be.sv
// Store queue between MEM stage and data bus: DEPTH-entry FIFO with registered bus
// outputs and load-conflict detection. Define STORE_COALESCE_EN to merge same-word stores.
module store_queue_be
  import store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [3:0]                 st_memop,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [31:0]                st_wdata,
  input  logic                       st_ovf,
  input  logic                       st_req,
  output logic                       st_ready,
  output logic                       exc_ades,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_conflict,
  output logic                       m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [3:0]                 m_byteen,
  output logic [31:0]                m_wdata,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic              st_is_st, st_ades;
  logic [ADDR_W-1:0] st_word;
  logic [3:0]        st_be;
  logic [31:0]       st_data;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [3:0]        be_d   [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [3:0]        m_byteen_q, m_byteen_d;
  logic [31:0]       m_wdata_q, m_wdata_d;

  logic              pop, accept, alloc, merge_hit, ld_hit;
  logic [ADDR_W-1:0] ld_word;

  store_lane_gen #(.ADDR_W(ADDR_W)) u_lane_gen (
    .valid     (st_valid),
    .memop     (st_memop),
    .addr      (st_addr),
    .wdata     (st_wdata),
    .ovf       (st_ovf),
    .is_st     (st_is_st),
    .ades      (st_ades),
    .word_addr (st_word),
    .byteen    (st_be),
    .lane_data (st_data)
  );

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] newest;
  assign newest = wr_q - PW'(1);
  // The head cannot absorb a merge in the cycle it leaves for the bus.
  assign merge_hit = (cnt_q != {CW{1'b0}}) && (addr_q[newest] == st_word) &&
                     !((newest == rd_q) && pop);
`else
  assign merge_hit = 1'b0;
`endif

  assign pop      = m_valid_q & m_ready;
  assign st_ready = (cnt_q != FULL_CNT) | merge_hit;
  assign accept   = st_is_st & ~st_ades & ~st_req & st_ready;
  assign alloc    = accept & ~merge_hit;
  assign exc_ades = st_ades;
  assign ld_word  = ld_addr & WORD_MASK;

  // Word-address match of a load against every occupied entry, head included.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == ld_word)) ld_hit = 1'b1;
      else                                    ld_hit = ld_hit;
    end
    ld_conflict = ld_valid & ld_hit;
  end

  // Next FIFO state: pop head, then allocate or merge; bus outputs preview the new head.
  always_comb begin
    addr_d = addr_q;
    be_d   = be_q;
    data_d = data_q;
    vld_d  = vld_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (alloc) begin
      addr_d[wr_q] = st_word;
      be_d[wr_q]   = st_be;
      data_d[wr_q] = st_data;
      vld_d[wr_q]  = 1'b1;
      wr_d         = wr_q + PW'(1);
`ifdef STORE_COALESCE_EN
    end else if (accept) begin
      be_d[newest]   = be_q[newest] | st_be;
      data_d[newest] = merge_lanes(data_q[newest], st_data, st_be);
`endif
    end else begin
      wr_d = wr_q;
    end
    cnt_d     = cnt_q + CW'(alloc) - CW'(pop);
    m_valid_d = (cnt_d != {CW{1'b0}});
    if (m_valid_d) begin
      m_addr_d   = addr_d[rd_d];
      m_byteen_d = be_d[rd_d];
      m_wdata_d  = data_d[rd_d];
    end else begin
      m_addr_d   = {ADDR_W{1'b0}};
      m_byteen_d = 4'b0000;
      m_wdata_d  = 32'h0000_0000;
    end
  end

  // State registers; asynchronous reset discards every pending store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        be_q[i]   <= 4'b0000;
        data_q[i] <= 32'h0000_0000;
      end
      vld_q      <= {DEPTH{1'b0}};
      wr_q       <= {PW{1'b0}};
      rd_q       <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      m_valid_q  <= 1'b0;
      m_addr_q   <= {ADDR_W{1'b0}};
      m_byteen_q <= 4'b0000;
      m_wdata_q  <= 32'h0000_0000;
    end else begin
      addr_q     <= addr_d;
      be_q       <= be_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_byteen_q <= m_byteen_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_byteen = m_byteen_q;
  assign m_wdata  = m_wdata_q;
  assign q_count  = cnt_q;

endmodule

// File: tb/tb_store_queue_be.sv
// Scoreboard bench for store_queue_be: a queue-level reference model predicts
// acceptance, AdES and conflicts; a negedge monitor checks every bus transfer.
module tb_store_queue_be;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              st_valid = 1'b0, st_ovf = 1'b0, st_req = 1'b0;
  logic [3:0]        st_memop = 4'd0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_wdata = '0;
  logic              st_ready, exc_ades, ld_conflict;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              m_valid, m_ready = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_byteen;
  logic [31:0]       m_wdata;
  logic [CW-1:0]     q_count;

  always #5 clk = ~clk;

  store_queue_be #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_memop(st_memop),
    .st_addr(st_addr), .st_wdata(st_wdata), .st_ovf(st_ovf), .st_req(st_req),
    .st_ready(st_ready), .exc_ades(exc_ades), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .m_valid(m_valid), .m_addr(m_addr), .m_byteen(m_byteen),
    .m_wdata(m_wdata), .m_ready(m_ready), .q_count(q_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];
  ent_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd4:    return 4;
      4'd5:    return 2;
      4'd6:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_rng(input logic [31:0] a, input int lo, input int hi);
    return (a >= 32'(lo)) && (a <= 32'(hi));
  endfunction

  function automatic bit model_ades(input logic [3:0] op, input logic [31:0] a, input bit ovf);
    int  sz;
    bit  mis, mapped, tv;
    sz = op_size(op);
    if (sz == 0) return 1'b0;
    mis    = (a % sz) != 0;
    mapped = (a <= 32'h2FFF) || in_rng(a, 'h7F00, 'h7F0B) || in_rng(a, 'h7F10, 'h7F1B) ||
             in_rng(a, 'h7F20, 'h7F23);
    tv     = in_rng(a, 'h7F08, 'h7F0B) || in_rng(a, 'h7F18, 'h7F1B) ||
             (sz < 4 && in_rng(a, 'h7F00, 'h7F1B));
    return ovf || mis || !mapped || tv;
  endfunction

  // One clock: drive at posedge+1, predict and check at posedge+3, update the model.
  task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit ovf, input bit req,
                       input bit ldv, input logic [31:0] la, input bit mr);
    int   sz;
    bit   is_st, ades, pop, merge, rdy, conf, acc;
    ent_t e;
    logic [31:0] mask;
    @(posedge clk);
    #1;
    st_valid = v; st_memop = op; st_addr = a; st_wdata = d; st_ovf = ovf; st_req = req;
    ld_valid = ldv; ld_addr = la; m_ready = mr;
    #2;
    sz    = op_size(op);
    is_st = v && (sz != 0);
    e.addr = a & ~32'h3;
    pop   = (model_q.size() != 0) && mr;
    merge = 1'b0;
`ifdef STORE_COALESCE_EN
    if (model_q.size() != 0 && model_q[$].addr == e.addr && !(model_q.size() == 1 && pop))
      merge = 1'b1;
`endif
    rdy  = (model_q.size() != DEPTH) || merge;
    ades = v && model_ades(op, a, ovf);
    conf = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr == (la & ~32'h3)) conf = 1'b1;
    conf = conf && ldv;
    chk("st_ready", 72'(st_ready), 72'(rdy));
    chk("exc_ades", 72'(exc_ades), 72'(ades));
    chk("ld_conflict", 72'(ld_conflict), 72'(conf));
    chk("q_count", 72'(q_count), 72'(model_q.size()));
    chk("m_valid", 72'(m_valid), 72'(model_q.size() != 0));
    if (model_q.size() == 0) chk("empty_bus_zero", {m_addr, m_byteen, m_wdata}, 72'd0);
    acc  = is_st && !ades && !req && rdy;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    e.be   = 4'(((1 << sz) - 1) << (a % 4));
    e.data = (d & mask) << (8 * (a % 4));
    if (pop) sb_q.push_back(model_q.pop_front());
    if (acc) begin
      if (merge) begin
        ent_t t;
        t = model_q[$];
        for (int b = 0; b < 4; b++) if (e.be[b]) t.data[8*b +: 8] = e.data[8*b +: 8];
        t.be = t.be | e.be;
        model_q[model_q.size() - 1] = t;
      end else begin
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit mr);
    cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, mr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    st_valid = 1'b0; ld_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_q_count", 72'(q_count), 72'd0);
    chk("rst_m_valid", 72'(m_valid), 72'd0);
    chk("rst_bus_zero", {m_addr, m_byteen, m_wdata}, 72'd0);
    model_q.delete();
    sb_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every accepted bus beat must match the next scoreboard entry.
  initial begin
    ent_t        e;
    logic [67:0] held;
    bit          hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold = 1'b0;
      end else if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got addr %0h with no expected entry", m_addr);
        end else begin
          e = sb_q.pop_front();
          chk("bus_addr", 72'(m_addr), 72'(e.addr));
          chk("bus_byteen", 72'(m_byteen), 72'(e.be));
          chk("bus_wdata", 72'(m_wdata), 72'(e.data));
        end
        hold = 1'b0;
      end else if (m_valid) begin
`ifndef STORE_COALESCE_EN
        if (hold) chk("bus_stable", 72'({m_addr, m_byteen, m_wdata}), 72'(held));
`endif
        held = {m_addr, m_byteen, m_wdata};
        hold = 1'b1;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a, la;
    logic [3:0]  op;
    #2;
    chk("init_q_count", 72'(q_count), 72'd0);
    chk("init_m_valid", 72'(m_valid), 72'd0);
    chk("init_bus_zero", {m_addr, m_byteen, m_wdata}, 72'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    cycle(1'b1, 4'd6, 32'h1003, 32'h0000_00AB, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    chk("sb_head_valid", 72'(m_valid), 72'd1);
    chk("sb_head_addr", 72'(m_addr), 72'h1000);
    chk("sb_head_byteen", 72'(m_byteen), 72'b1000);
    chk("sb_head_wdata", 72'(m_wdata), 72'hAB00_0000);

    cycle(1'b1, 4'd5, 32'h1001, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("sh_misalign_ades", 72'(exc_ades), 72'd1);
    idle(1'b1);
    chk("sh_misalign_count", 72'(q_count), 72'd0);
    cycle(1'b1, 4'd4, 32'h7F08, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("sw_timer_cnt_ades", 72'(exc_ades), 72'd1);
    cycle(1'b1, 4'd5, 32'h7F04, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("sh_timer_ades", 72'(exc_ades), 72'd1);

    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, 4'd4, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0,
            1'b0, 32'h0, 1'b0);
      if (i == DEPTH) chk("full_not_ready", 72'(st_ready), 72'd0);
    end
    repeat (DEPTH + 2) idle(1'b1);

    cycle(1'b1, 4'd4, 32'h2000, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2002, 1'b0);
    chk("ld_conflict_hit", 72'(ld_conflict), 72'd1);
    cycle(1'b1, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2004, 1'b0);
    chk("ld_conflict_miss", 72'(ld_conflict), 72'd0);
    repeat (2) idle(1'b1);

    cycle(1'b1, 4'd4, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("req_no_ades", 72'(exc_ades), 72'd0);
    idle(1'b1);
    chk("req_not_queued", 72'(q_count), 72'd0);

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'd4, 32'h300 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    do_reset();

    cycle(1'b1, 4'd6, 32'h10, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 4'd6, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
`ifdef STORE_COALESCE_EN
    chk("coalesce_count", 72'(q_count), 72'd1);
    chk("coalesce_byteen", 72'(m_byteen), 72'b0011);
    chk("coalesce_wdata", 72'(m_wdata), 72'h0000_2211);
`else
    chk("no_coalesce_count", 72'(q_count), 72'd2);
`endif
    repeat (3) idle(1'b1);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h1000 + 32'($urandom_range(0, 31));
        1:       a = 32'h7F00 + 32'($urandom_range(0, 47));
        2:       a = 32'h2FF0 + 32'($urandom_range(0, 31));
        3:       a = $urandom;
        default: a = 32'h1000 + 32'($urandom_range(0, 15));
      endcase
      op = 4'($urandom_range(3, 7));
      la = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000 + 32'($urandom_range(0, 31));
      cycle(($urandom % 8) != 0, op, a, $urandom, ($urandom % 16) == 0,
            ($urandom % 10) == 0, ($urandom % 2) == 0, la, ($urandom % 3) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    repeat (DEPTH + 4) idle(1'b1);
    chk("final_drained", 72'(q_count), 72'd0);
    chk("final_scoreboard_empty", 72'(sb_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
